// File: rtl/rs_multi_cdb.sv
// Reservation station for the Tomasulo core. Buffers renamed ALU
// instructions, snoops several CDB channels for operand wakeup, and
// dispatches the oldest ready entry to the ALU. An age matrix tracks
// issue order so age survives any free/refill pattern.
module rs_multi_cdb #(
  parameter int unsigned RS_SIZE      = 16,
  parameter int unsigned TAG_W        = 5,
  parameter int unsigned TAG_NULL     = 0,
  parameter int unsigned CDB_CHANNELS = 2,
  parameter int unsigned OP_W         = 6
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic                         flush_in,
  input  logic                         issue_valid_in,
  input  logic [OP_W-1:0]              issue_op_in,
  input  logic [31:0]                  issue_inst_in,
  input  logic [31:0]                  issue_pc_in,
  input  logic [31:0]                  issue_imm_in,
  input  logic [31:0]                  issue_vj_in,
  input  logic [31:0]                  issue_vk_in,
  input  logic [TAG_W-1:0]             issue_qj_in,
  input  logic [TAG_W-1:0]             issue_qk_in,
  input  logic [TAG_W-1:0]             issue_entry_in,
  output logic                         is_full_out,
  output logic [$clog2(RS_SIZE):0]     free_count_out,
  input  logic [CDB_CHANNELS-1:0]      cdb_valid_in,
  input  logic [CDB_CHANNELS*TAG_W-1:0] cdb_tag_in,
  input  logic [CDB_CHANNELS*32-1:0]   cdb_value_in,
  input  logic                         exec_ready_in,
  output logic                         exec_valid_out,
  output logic [OP_W-1:0]              exec_op_out,
  output logic [31:0]                  exec_inst_out,
  output logic [31:0]                  exec_pc_out,
  output logic [31:0]                  exec_imm_out,
  output logic [31:0]                  exec_vj_out,
  output logic [31:0]                  exec_vk_out,
  output logic [TAG_W-1:0]             exec_entry_out
);

  localparam int unsigned IDX_W = $clog2(RS_SIZE);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [TAG_W-1:0] NULL_TAG = TAG_W'(TAG_NULL);

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [31:0]      inst;
    logic [31:0]      pc;
    logic [31:0]      imm;
    logic [31:0]      vj;
    logic [31:0]      vk;
    logic [TAG_W-1:0] qj;
    logic [TAG_W-1:0] qk;
    logic [TAG_W-1:0] dest;
  } entry_t;

  entry_t             ent   [RS_SIZE];
  logic [RS_SIZE-1:0] busy;
  // older[j][i] set means entry j was issued before entry i
  logic [RS_SIZE-1:0] older [RS_SIZE];

  logic [CNT_W-1:0]   free_cnt;
  logic [IDX_W-1:0]   ins_idx;
  logic               ins_ok;
  logic [IDX_W-1:0]   disp_idx;
  logic               disp_ok;
  logic [RS_SIZE-1:0] ready;
  logic [RS_SIZE-1:0] wj_hit;
  logic [RS_SIZE-1:0] wk_hit;
  logic [31:0]        wj_val [RS_SIZE];
  logic [31:0]        wk_val [RS_SIZE];
  logic               bj_hit;
  logic               bk_hit;
  logic [31:0]        bj_val;
  logic [31:0]        bk_val;
  entry_t             new_ent;

  // Tag lookup across CDB channels; lowest channel index wins on duplicates
  function automatic logic cdb_match(
    input  logic [TAG_W-1:0]              q,
    input  logic [CDB_CHANNELS-1:0]       v,
    input  logic [CDB_CHANNELS*TAG_W-1:0] t,
    input  logic [CDB_CHANNELS*32-1:0]    d,
    output logic [31:0]                   val
  );
    logic hit;
    hit = 1'b0;
    val = '0;
    for (int c = int'(CDB_CHANNELS) - 1; c >= 0; c--) begin
      if (q != NULL_TAG && v[c] && t[c*TAG_W +: TAG_W] == q) begin
        hit = 1'b1;
        val = d[c*32 +: 32];
      end
    end
    return hit;
  endfunction

  // Free-slot count and lowest-index empty slot for issue
  always_comb begin
    free_cnt = '0;
    ins_idx  = '0;
    ins_ok   = 1'b0;
    for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_cnt = free_cnt + CNT_W'(1);
        ins_ok   = 1'b1;
        ins_idx  = IDX_W'(i);
      end
    end
  end

  assign free_count_out = free_cnt;
  assign is_full_out    = !ins_ok;

  // Oldest ready entry: ready and no other ready entry is older
  always_comb begin
    logic blocked;
    blocked  = 1'b0;
    disp_idx = '0;
    disp_ok  = 1'b0;
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      ready[i] = busy[i] && ent[i].qj == NULL_TAG && ent[i].qk == NULL_TAG;
    end
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      blocked = 1'b0;
      for (int j = 0; j < int'(RS_SIZE); j++) begin
        if (ready[j] && older[j][i]) blocked = 1'b1;
      end
      if (ready[i] && !blocked) begin
        disp_ok  = 1'b1;
        disp_idx = IDX_W'(i);
      end
    end
  end

  // Operand wakeup for stored entries and bypass for the incoming issue
  always_comb begin
    for (int i = 0; i < int'(RS_SIZE); i++) begin
      wj_hit[i] = cdb_match(ent[i].qj, cdb_valid_in, cdb_tag_in, cdb_value_in, wj_val[i]);
      wk_hit[i] = cdb_match(ent[i].qk, cdb_valid_in, cdb_tag_in, cdb_value_in, wk_val[i]);
    end
    bj_hit = cdb_match(issue_qj_in, cdb_valid_in, cdb_tag_in, cdb_value_in, bj_val);
    bk_hit = cdb_match(issue_qk_in, cdb_valid_in, cdb_tag_in, cdb_value_in, bk_val);
    new_ent.op   = issue_op_in;
    new_ent.inst = issue_inst_in;
    new_ent.pc   = issue_pc_in;
    new_ent.imm  = issue_imm_in;
    new_ent.vj   = bj_hit ? bj_val : issue_vj_in;
    new_ent.vk   = bk_hit ? bk_val : issue_vk_in;
    new_ent.qj   = bj_hit ? NULL_TAG : issue_qj_in;
    new_ent.qk   = bk_hit ? NULL_TAG : issue_qk_in;
    new_ent.dest = issue_entry_in;
  end

  // Entry state, age matrix and dispatch registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy           <= '0;
      exec_valid_out <= 1'b0;
      exec_op_out    <= '0;
      exec_inst_out  <= '0;
      exec_pc_out    <= '0;
      exec_imm_out   <= '0;
      exec_vj_out    <= '0;
      exec_vk_out    <= '0;
      exec_entry_out <= '0;
      for (int i = 0; i < int'(RS_SIZE); i++) begin
        ent[i]   <= '0;
        older[i] <= '0;
      end
    end else if (rdy_in) begin
      if (flush_in) begin
        busy           <= '0;
        exec_valid_out <= 1'b0;
      end else begin
        for (int i = 0; i < int'(RS_SIZE); i++) begin
          if (busy[i] && wj_hit[i]) begin
            ent[i].vj <= wj_val[i];
            ent[i].qj <= NULL_TAG;
          end
          if (busy[i] && wk_hit[i]) begin
            ent[i].vk <= wk_val[i];
            ent[i].qk <= NULL_TAG;
          end
        end
        if (exec_ready_in && disp_ok) begin
          busy[disp_idx] <= 1'b0;
          exec_valid_out <= 1'b1;
          exec_op_out    <= ent[disp_idx].op;
          exec_inst_out  <= ent[disp_idx].inst;
          exec_pc_out    <= ent[disp_idx].pc;
          exec_imm_out   <= ent[disp_idx].imm;
          exec_vj_out    <= ent[disp_idx].vj;
          exec_vk_out    <= ent[disp_idx].vk;
          exec_entry_out <= ent[disp_idx].dest;
        end else begin
          exec_valid_out <= 1'b0;
        end
        if (issue_valid_in && ins_ok) begin
          busy[ins_idx]  <= 1'b1;
          ent[ins_idx]   <= new_ent;
          older[ins_idx] <= '0;
          for (int j = 0; j < int'(RS_SIZE); j++) begin
            if (IDX_W'(j) != ins_idx) older[j][ins_idx] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: doc/rs_multi_cdb.md
Name: rs_multi_cdb

Overview:
- Parametrised reservation station for the Tomasulo core.
- Buffers renamed ALU instructions until both operands are available.
- Snoops N common-data-bus channels and dispatches the oldest ready entry to the ALU under an accept handshake.
- Sits between the decoder/register-file issue stage and the ALU, with the ROB-rollback flush path.

Parameters:
- RS_SIZE, 16, number of entries (power of two, 2..64)
- TAG_W, 5, ROB entry tag width
- TAG_NULL, 0, tag value meaning "operand already valid"
- CDB_CHANNELS, 2, number of broadcast channels snooped
- OP_W, 6, internal opcode width

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  asynchronous active-high reset
- rdy_in  input  1  core ready; low freezes the block
- flush_in  input  1  mispredict rollback; empties the station
- issue_valid_in  input  1  new instruction this cycle
- issue_op_in  input  OP_W  opcode
- issue_inst_in  input  32  raw instruction
- issue_pc_in  input  32  instruction pc
- issue_imm_in  input  32  immediate
- issue_vj_in / issue_vk_in  input  32 each  operand values
- issue_qj_in / issue_qk_in  input  TAG_W each  operand producer tags
- issue_entry_in  input  TAG_W  destination ROB tag
- is_full_out  output  1  no empty entry
- free_count_out  output  $clog2(RS_SIZE)+1  number of empty entries
- cdb_valid_in  input  CDB_CHANNELS  per-channel broadcast valid
- cdb_tag_in  input  CDB_CHANNELS*TAG_W  flattened tags, channel 0 in the LSBs
- cdb_value_in  input  CDB_CHANNELS*32  flattened values, channel 0 in the LSBs
- exec_ready_in  input  1  ALU can accept an instruction this cycle
- exec_valid_out  output  1  dispatch pulse to the ALU
- exec_op_out  output  OP_W  registered dispatch field
- exec_inst_out / exec_pc_out / exec_imm_out / exec_vj_out / exec_vk_out  output  32 each  registered dispatch fields
- exec_entry_out  output  TAG_W  registered dispatch field

Behaviour:
Reset and status:
- Reset: all entries empty, all exec_* outputs 0, is_full_out 0, free_count_out = RS_SIZE.
- is_full_out and free_count_out are combinational from the current entry state. Entries freed or filled at this edge are not counted until the next cycle.

Priority at each rising edge:
- rst_in overrides everything.
- Else if rdy_in is low: hold all state and outputs; issue, CDB and flush are ignored.
- Else if flush_in is high: all entries empty, exec_valid_out <= 0, and any issue or dispatch this cycle is dropped.
- Otherwise issue, wakeup and dispatch all happen in the same cycle.

Issue:
- When issue_valid_in is high and is_full_out is low, write the lowest-index empty entry.
- Issue while full is ignored with no state change. The bench flags it as a protocol error.
- Same-cycle bypass: if issue_qj_in or issue_qk_in is not TAG_NULL and matches a valid CDB tag this cycle, store that CDB value and set the stored Q to TAG_NULL.

Wakeup:
- For every occupied entry with Qj or Qk not TAG_NULL that matches a valid CDB channel tag: capture the value and set Q to TAG_NULL.
- If several channels carry the same tag, the lowest channel index wins.
- Qj and Qk may wake in the same cycle from different channels.

Ready and dispatch:
- An entry is ready when it is occupied and Qj == Qk == TAG_NULL, judged on registered state.
- Minimum latency is therefore one cycle: an entry issued with both operands valid at edge N is eligible at edge N+1.
- Each cycle with exec_ready_in high and at least one ready entry: select the ready entry with the earliest issue, load it into the exec_* registers, set exec_valid_out <= 1, and free the entry at this edge.
- Otherwise exec_valid_out <= 0 and the exec data registers hold their values.
- At most one dispatch per cycle.
- Age order must survive arbitrary free/refill patterns; slot index is not a substitute.

Boundaries:
- A freed slot is reusable by an issue at the next edge, not the same edge.
- When the station is full and a dispatch occurs, the issue that cycle is still ignored.

Test Plan (RS_SIZE=4, CDB_CHANNELS=2, TAG_NULL=0):
1. Issue A (qj=qk=0, vj=5, vk=7, entry=3), exec_ready_in=1 -> the cycle after issue: exec_valid_out=1, exec_vj_out=5, exec_vk_out=7, exec_entry_out=3; free_count_out returns to 4.
2. Issue B (qj=6); two cycles later ch1 broadcasts tag 6 with value 0x1234 -> the next cycle: exec_valid_out=1, exec_vj_out=0x1234.
3. Issue C (qk=9) in the same cycle ch0 broadcasts tag 9 with value 0xAA -> C dispatches one cycle later with exec_vk_out=0xAA (bypass; no second broadcast needed).
4. Hold exec_ready_in=0 and issue D, E, F, G all ready -> is_full_out=1, free_count_out=0, and a fifth issue is ignored. Then free slot 0 only, issue H, raise exec_ready_in -> dispatch order is E, F, G, H.
5. Fill 3 entries and assert flush_in together with issue_valid_in -> next cycle free_count_out=4 and exec_valid_out=0; a subsequent CDB for their tags causes no dispatch.
6. Drop rdy_in for 3 cycles while a CDB wakes an entry and exec_ready_in=1 -> no state change and no dispatch. After rdy_in rises, the entry still waits until its tag is rebroadcast.
